// File: rtl/cla_seg_addsub.sv
// Multi-cycle adder/subtractor: WIDTH-bit result computed SEG bits per cycle,
// LSB segment first, with the inter-segment carry held in a register.

module cla_seg_cla4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic [4:1] o_c
);
    logic [3:0] w_g, w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is expanded from i_c directly; no bit waits on its neighbour.
    assign o_c[1] = w_g[0] | (w_p[0] & i_c);
    assign o_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign o_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign o_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s = w_p ^ {o_c[3:1], i_c};
endmodule

module cla_seg_addsub #(
    parameter int WIDTH = 256,
    parameter int SEG   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;
    localparam int NGRP = SEG / 4;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state, w_nstate;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_op1, r_op2, r_sum;
    logic              r_carry, r_cout, r_ovf;

    logic [SEG-1:0]    w_a, w_b, w_s;
    logic [SEG:0]      w_c;
    logic              w_accept, w_last;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == CW'(NSEG - 1));
    assign w_a      = r_op1[r_cnt*SEG +: SEG];
    assign w_b      = r_op2[r_cnt*SEG +: SEG];
    assign w_c[0]   = r_carry;

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        cla_seg_cla4 u_cla4 (
            .i_a (w_a[4*g +: 4]),
            .i_b (w_b[4*g +: 4]),
            .i_c (w_c[4*g]),
            .o_s (w_s[4*g +: 4]),
            .o_c (w_c[4*g+4 : 4*g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_nstate = S_RUN;
            S_RUN:   if (w_last)    w_nstate = S_DONE;
            S_DONE:  if (out_ready) w_nstate = S_IDLE;
            default:                w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract is op1 + ~op2 + ~borrow, so the datapath only ever adds.
            r_cnt   <= '0;
            r_op1   <= op1;
            r_op2   <= sub ? ~op2 : op2;
            r_carry <= sub ? ~cin : cin;
        end else if (r_state == S_RUN) begin
            r_sum[r_cnt*SEG +: SEG] <= w_s;
            r_carry <= w_c[SEG];
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_cout <= w_c[SEG];
                r_ovf  <= w_c[SEG] ^ w_c[SEG-1];
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_seg_addsub.sv
// Directed and model-checked bench for cla_seg_addsub at 256/64 and 32/8.

module tb_cla_seg_addsub;
    localparam int W    = 256;
    localparam int NSEG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid = 0, a_in_ready, a_sub = 0, a_cin = 0;
    logic         a_out_valid, a_out_ready = 0, a_cout, a_ovf;
    logic [W-1:0] a_op1 = '0, a_op2 = '0, a_sum;

    logic         b_in_valid = 0, b_in_ready, b_sub = 0, b_cin = 0;
    logic         b_out_valid, b_out_ready = 0, b_cout, b_ovf;
    logic [31:0]  b_op1 = '0, b_op2 = '0, b_sum;

    cla_seg_addsub #(.WIDTH(256), .SEG(64)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op1(a_op1), .op2(a_op2), .sub(a_sub), .cin(a_cin),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sum(a_sum), .cout(a_cout), .ovf(a_ovf)
    );

    cla_seg_addsub #(.WIDTH(32), .SEG(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op1(b_op1), .op2(b_op2), .sub(b_sub), .cin(b_cin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum(b_sum), .cout(b_cout), .ovf(b_ovf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference built from plain wide arithmetic: {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s, input logic c);
        logic [W:0]   u;
        logic [W+1:0] r;
        logic         co;
        if (s) begin
            u  = {1'b0, x} - {1'b0, y} - (W+1)'(c);
            co = ~u[W];
            r  = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y} - (W+2)'(c);
        end else begin
            u  = {1'b0, x} + {1'b0, y} + (W+1)'(c);
            co = u[W];
            r  = {{2{x[W-1]}}, x} + {{2{y[W-1]}}, y} + (W+2)'(c);
        end
        return {~(r[W+1:W-1] == 3'b000 || r[W+1:W-1] == 3'b111), co, u[W-1:0]};
    endfunction

    // Issue one op to the 256-bit instance, wait for the result, leave it held in DONE.
    task automatic issue_a(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input logic c, output int lat);
        a_op1 = x; a_op2 = y; a_sub = s; a_cin = c; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_op1 = '0; a_op2 = '0;
        lat = 0;
        while (!a_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_a(input string tag);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk({tag, "_ready_after"}, W'(a_in_ready), 1);
        chk({tag, "_valid_after"}, W'(a_out_valid), 0);
    endtask

    int          lat, t_prev, t_acc, cyc, n;
    logic [W-1:0] hsum;
    logic [W+1:0] e;
    logic [W-1:0] x, y;
    logic         s, c;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", W'(a_in_ready), 1);
        chk("rst_valid", W'(a_out_valid), 0);
        chk("rst_sum",   W'(a_sum), 0);
        chk("rst_cout",  W'(a_cout), 0);
        chk("rst_ovf",   W'(a_ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // all ones + 1 ripples a carry across every segment boundary
        issue_a({W{1'b1}}, W'(1), 1'b0, 1'b0, lat);
        chk("t1_lat",  W'(lat), NSEG);
        chk("t1_sum",  W'(a_sum), 0);
        chk("t1_cout", W'(a_cout), 1);
        chk("t1_ovf",  W'(a_ovf), 0);
        release_a("t1");

        issue_a({1'b1, 255'h0} | W'('ha), {1'b1, 255'h0} | W'('hc2), 1'b0, 1'b0, lat);
        chk("t2_sum",  W'(a_sum), W'('hcc));
        chk("t2_cout", W'(a_cout), 1);
        chk("t2_ovf",  W'(a_ovf), 1);
        release_a("t2");

        issue_a(W'(5), W'(7), 1'b1, 1'b0, lat);
        chk("t3_lat",  W'(lat), NSEG);
        chk("t3_sum",  W'(a_sum), {1'b0, {(W-1){1'b1}}, 1'b0});
        chk("t3_cout", W'(a_cout), 0);
        chk("t3_ovf",  W'(a_ovf), 0);
        release_a("t3");

        issue_a(W'(5), W'(7), 1'b1, 1'b1, lat);
        chk("t4_sum",  W'(a_sum), {1'b0, {(W-2){1'b1}}, 2'b01});
        chk("t4_cout", W'(a_cout), 0);
        chk("t4_ovf",  W'(a_ovf), 0);
        release_a("t4");

        // backpressure: result must hold and a stray in_valid must be dropped
        issue_a({W/2{2'b10}}, {W/2{2'b01}}, 1'b0, 1'b1, lat);
        hsum = a_sum;
        chk("t5_sum", W'(hsum), W'(0));
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a_in_valid = 1'b1; a_op1 = W'(3); a_op2 = W'(4);
            end else begin
                a_in_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk("t5_hold_valid", W'(a_out_valid), 1);
            chk("t5_hold_ready", W'(a_in_ready), 0);
            chk("t5_hold_sum",   W'(a_sum), W'(hsum));
            chk("t5_hold_cout",  W'(a_cout), 1);
            chk("t5_hold_ovf",   W'(a_ovf), 0);
        end
        a_in_valid = 1'b0;
        release_a("t5");

        // reset two cycles into RUN discards the partial result
        a_op1 = {W{1'b1}}; a_op2 = '0; a_sub = 0; a_cin = 0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", W'(a_out_valid), 0);
        chk("t6_rst_sum",   W'(a_sum), 0);
        chk("t6_rst_ready", W'(a_in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_a(W'(1), W'(1), 1'b0, 1'b0, lat);
        chk("t6_lat", W'(lat), NSEG);
        chk("t6_sum", W'(a_sum), W'(2));
        release_a("t6");

        // 32/8 instance: signed overflow into the MSB
        b_op1 = 32'h7FFF_FFFF; b_op2 = 32'h1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t7_lat",  W'(lat), 4);
        chk("t7_sum",  W'(b_sum), W'(32'h8000_0000));
        chk("t7_cout", W'(b_cout), 0);
        chk("t7_ovf",  W'(b_ovf), 1);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("t7_ready_after", W'(b_in_ready), 1);

        // back-to-back issue with out_ready held high, checked against the model
        cyc = 0;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_op1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        a_op2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        a_sub = 1'($urandom); a_cin = 1'($urandom);
        t_prev = 0;
        for (int i = 0; i < 100; i++) begin
            x = a_op1; y = a_op2; s = a_sub; c = a_cin;
            e = ref_op(x, y, s, c);
            @(posedge clk); #1;
            cyc++;
            t_acc = cyc;
            if (i > 0) chk("t8_gap", W'(t_acc - t_prev), NSEG + 2);
            t_prev = t_acc;
            a_op1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a_op2 = (i % 10 == 0) ? a_op1 : {$urandom, $urandom, $urandom, $urandom,
                                             $urandom, $urandom, $urandom, $urandom};
            a_sub = 1'($urandom); a_cin = 1'($urandom);
            n = 0;
            while (!a_out_valid && n < 20) begin
                @(posedge clk); #1;
                cyc++; n++;
            end
            chk("t8_lat",  W'(n), NSEG);
            chk("t8_sum",  W'(a_sum), W'(e[W-1:0]));
            chk("t8_cout", W'(a_cout), W'(e[W]));
            chk("t8_ovf",  W'(a_ovf), W'(e[W+1]));
            n = 0;
            while (!a_in_ready && n < 20) begin
                @(posedge clk); #1;
                cyc++; n++;
            end
            chk("t8_ready", W'(a_in_ready), 1);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
